imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered, handshaked immediate generator for the decode stage of the pipelined core. It accepts an instruction word and a format select, extracts and sign- or zero-extends the immediate to XLEN bits, and presents it through a two-entry skid buffer with valid/ready flow control. It adds U-type and CSR zimm formats, an illegal-format flag, XLEN generalisation and a synchronous flush.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous buffer clear (branch redirect / trap).
- in_valid  input  1  instruction and format valid.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  instruction word; bits [6:0] are ignored.
- in_immsrc  input  3  format select, imm_pkg::immsrc_e.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head entry.
- out_immext  output  XLEN  extended immediate of head entry.
- out_illegal  output  1  head entry had an undefined in_immsrc.

## Operation
- Formats, where s is instr[31] replicated to XLEN:
  - 000 I: s, instr[31:20].
  - 001 S: s, instr[31:25], instr[11:7].
  - 010 B: s, instr[7], instr[30:25], instr[11:8], 0.
  - 011 J: s, instr[19:12], instr[20], instr[30:21], 0.
  - 100 U: s above bit 31, instr[31:12], 12'b0.
  - 101 Z: zero-extended instr[19:15].
  - 110/111: immext = 0, illegal = 1.
- Codes 000–011 match the single-cycle extender encoding.
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Buffer FSM, state in imm_pkg::skid_state_e:
  - EMPTY: push goes to ONE.
  - ONE: push only goes to TWO; pop only goes to EMPTY; push and pop together stay in ONE, with the new entry becoming head.
  - TWO: pop goes to ONE, with the second entry promoted to head. Push is impossible.
- in_ready = (state != TWO), decoded directly from the state register with no combinational path from out_ready.
- FIFO order is strictly preserved. Entries are never dropped or duplicated.
- flush has priority over push and pop. State goes to EMPTY next cycle, and an input presented in the same cycle is discarded.
- Buffered immext and illegal values are held stable while out_valid && !out_ready.

## Timing
- Reset (rst_n low, asynchronous): state = EMPTY, out_valid = 0, out_immext = 0, out_illegal = 0, in_ready = 1. Reset asserted mid-operation discards all entries immediately.
- Latency: an entry accepted at edge N is visible on the outputs after edge N. There is no bypass, so out_valid is never combinational from in_valid.
- Throughput: one entry per cycle while out_ready is held high, with the FSM staying in ONE.
- With out_ready low, at most two entries are absorbed. in_ready falls after the second accept.
- After a flush, out_valid = 0 and in_ready = 1 in the next cycle. out_immext is don't-care but must not be X-propagating; it holds its last value.
- Outputs are registered. Critical path is instr → format mux → entry register.

## Structure
- imm_pkg contains:
  - immsrc_e, a 3-bit enum: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z.
  - skid_state_e: EMPTY, ONE, TWO.
  - A localparam for the illegal-code default value.
- Sub-module imm_decode: purely combinational, parameterised by XLEN. Inputs instr[31:7] and immsrc; outputs immext and illegal. It is instantiated once, at the input side of the buffer.
- imm_gen_stage holds the two entry registers, the FSM and the handshake logic only.

## Test plan
- XLEN=32, out_ready=1. Stream in order:
  - 0xFFF00093 / I → 0xFFFFFFFF.
  - 0xFE000EE3 / B → 0xFFFFFFFC.
  - 0x0080006F / J → 0x00000008.
  - 0x123450B7 / U → 0x12345000.
  - Each output appears one cycle after its accept, at one per cycle.
- XLEN=64: 0x80000037 / U → 0xFFFFFFFF80000000. 0x30015073 / Z → 0x0000000000000002.
- Backpressure with out_ready=0:
  - Push A=0x00100093 (I, 1), B=0x00200093 (I, 2), C=0x00300093 (I, 3).
  - in_ready drops after B, and C is held at the input.
  - Raise out_ready; outputs are 1, 2, 3 in order, with no loss.
- Illegal code: in_immsrc=3'b111 with any instr → out_illegal=1, out_immext=0. The following legal entry has out_illegal=0.
- Flush:
  - Flush in state TWO with in_valid high → out_valid=0 next cycle and the input is discarded.
  - The next push appears normally one cycle after its accept.
- Reset: assert rst_n low asynchronously mid-cycle in state ONE → outputs go to zero immediately, and in_ready=1.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator: format select
// encoding, skid-buffer occupancy states and the illegal-format fill value.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_Z = 3'b101
  } immsrc_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } skid_state_e;

  localparam logic [31:0] IMM_ILLEGAL_VALUE = 32'h0000_0000;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: builds a 32-bit immediate per format,
// then sign- or zero-extends it to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     i_instr,
  input  logic [2:0]      i_immsrc,
  output logic [XLEN-1:0] o_immext,
  output logic            o_illegal
);

  logic [31:0] w_imm32;
  logic        w_sext;

  // Every signed format is fully formed at 32 bits, so one extension covers XLEN=64.
  always_comb begin
    w_imm32   = IMM_ILLEGAL_VALUE;
    w_sext    = 1'b1;
    o_illegal = 1'b0;
    case (immsrc_e'(i_immsrc))
      IMM_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: w_imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25],
                        i_instr[11:8], 1'b0};
      IMM_J: w_imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20],
                        i_instr[30:21], 1'b0};
      IMM_U: w_imm32 = {i_instr[31:12], 12'h000};
      IMM_Z: begin
        w_imm32 = {27'd0, i_instr[19:15]};
        w_sext  = 1'b0;
      end
      default: begin
        w_imm32   = IMM_ILLEGAL_VALUE;
        w_sext    = 1'b0;
        o_illegal = 1'b1;
      end
    endcase
  end

  assign o_immext = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: decodes at the input, then buffers results
// in a two-entry skid buffer so in_ready depends only on registered state.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_immsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_immext,
  output logic            out_illegal
);

  skid_state_e     r_state;
  logic [XLEN-1:0] r_head_imm;
  logic            r_head_ill;
  logic [XLEN-1:0] r_tail_imm;
  logic            r_tail_ill;

  logic [XLEN-1:0] w_dec_imm;
  logic            w_dec_ill;
  logic            w_push;
  logic            w_pop;
  logic            w_unused_opcode;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .i_instr  (in_instr[31:7]),
    .i_immsrc (in_immsrc),
    .o_immext (w_dec_imm),
    .o_illegal(w_dec_ill)
  );

  assign w_unused_opcode = &{1'b0, in_instr[6:0]};

  assign in_ready    = (r_state != TWO);
  assign out_valid   = (r_state != EMPTY);
  assign out_immext  = r_head_imm;
  assign out_illegal = r_head_ill;
  assign w_push      = in_valid && in_ready;
  assign w_pop       = out_valid && out_ready;

  // Occupancy FSM and entry registers; entry data is left untouched on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_head_imm <= '0;
      r_head_ill <= 1'b0;
      r_tail_imm <= '0;
      r_tail_ill <= 1'b0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_head_imm <= w_dec_imm;
            r_head_ill <= w_dec_ill;
            r_state    <= ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_head_imm <= w_dec_imm;
            r_head_ill <= w_dec_ill;
          end else if (w_push) begin
            r_tail_imm <= w_dec_imm;
            r_tail_ill <= w_dec_ill;
            r_state    <= TWO;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            r_head_imm <= r_tail_imm;
            r_head_ill <= r_tail_ill;
            r_state    <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share stimulus and are
// compared against a queue-based reference model plus directed vectors.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_immsrc;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_immext32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_immext64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .in_instr(in_instr), .in_immsrc(in_immsrc),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_immext(out_immext32), .out_illegal(out_illegal32)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .in_instr(in_instr), .in_immsrc(in_immsrc),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_immext(out_immext64), .out_illegal(out_illegal64)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  src;
  } ent_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] exp32;
    logic [63:0] exp64;
    logic        ill;
  } vec_t;

  ent_t q[$];
  vec_t vecs[10];

  // Reference immediate: sign-extended arithmetic value of the format's field, truncated to xlen.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          input int xlen);
    longint      v;
    logic [63:0] r;
    case (src)
      3'd0:    v = longint'($signed(ins[31:20]));
      3'd1:    v = longint'($signed({ins[31:25], ins[11:7]}));
      3'd2:    v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'd3:    v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      3'd4:    v = longint'($signed({ins[31:12], 12'h000}));
      3'd5:    v = longint'({59'd0, ins[19:15]});
      default: v = 64'sd0;
    endcase
    r = v;
    if (xlen == 32) r = {32'h0, r[31:0]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic pop, push;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      pop  = (q.size() > 0) && out_ready;
      push = in_valid && (q.size() < 2);
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{instr: in_instr, src: in_immsrc});
    end
  endtask

  task automatic monitor();
    chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
    chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
    chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
    chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("model_imm32", 64'(out_immext32), ref_imm(q[0].instr, q[0].src, 32));
      chk("model_imm64", out_immext64, ref_imm(q[0].instr, q[0].src, 64));
      chk("model_ill32", 64'(out_illegal32), 64'(q[0].src > 3'd5));
      chk("model_ill64", 64'(out_illegal64), 64'(q[0].src > 3'd5));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    monitor();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src);
    in_valid  = v;
    in_instr  = ins;
    in_immsrc = src;
  endtask

  task automatic chk_head(input string name, input logic [63:0] exp32, input logic [63:0] exp64);
    chk({name, "_v32"}, 64'(out_valid32), 64'd1);
    chk({name, "_imm32"}, 64'(out_immext32), exp32);
    chk({name, "_imm64"}, out_immext64, exp64);
  endtask

  initial begin
    vecs[0] = '{32'hFFF00093, 3'b000, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1] = '{32'hFE000EE3, 3'b010, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2] = '{32'h0080006F, 3'b011, 64'h00000008, 64'h0000000000000008, 1'b0};
    vecs[3] = '{32'h123450B7, 3'b100, 64'h12345000, 64'h0000000012345000, 1'b0};
    vecs[4] = '{32'h80000037, 3'b100, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[5] = '{32'h30015073, 3'b101, 64'h00000002, 64'h0000000000000002, 1'b0};
    vecs[6] = '{32'hFE112E23, 3'b001, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[7] = '{32'hFFFFFFFF, 3'b111, 64'h00000000, 64'h0000000000000000, 1'b1};
    vecs[8] = '{32'h00100093, 3'b000, 64'h00000001, 64'h0000000000000001, 1'b0};
    vecs[9] = '{32'hDEADBEEF, 3'b110, 64'h00000000, 64'h0000000000000000, 1'b1};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 3'b000);
    #3;
    chk("rst_valid32", 64'(out_valid32), 64'd0);
    chk("rst_ready32", 64'(in_ready32), 64'd1);
    chk("rst_imm32", 64'(out_immext32), 64'd0);
    chk("rst_ill32", 64'(out_illegal32), 64'd0);
    chk("rst_imm64", out_immext64, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();

    // Streaming at full rate: each entry is visible right after its accept edge.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].src);
      cycle();
      chk_head($sformatf("vec%0d", i), vecs[i].exp32, vecs[i].exp64);
      chk($sformatf("vec%0d_ill32", i), 64'(out_illegal32), 64'(vecs[i].ill));
      chk($sformatf("vec%0d_ill64", i), 64'(out_illegal64), 64'(vecs[i].ill));
      chk($sformatf("vec%0d_rdy", i), 64'(in_ready32), 64'd1);
    end
    drive(1'b0, 32'h0, 3'b000);
    cycle();
    chk("stream_drain", 64'(out_valid32), 64'd0);

    // Backpressure: two absorbed, third held until space opens.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'b000);
    cycle();
    chk("bp_rdyA", 64'(in_ready32), 64'd1);
    chk_head("bpA", 64'd1, 64'd1);
    drive(1'b1, 32'h00200093, 3'b000);
    cycle();
    chk("bp_rdyB", 64'(in_ready32), 64'd0);
    chk_head("bpB", 64'd1, 64'd1);
    drive(1'b1, 32'h00300093, 3'b000);
    cycle();
    chk("bp_rdyC", 64'(in_ready32), 64'd0);
    chk_head("bpC_hold", 64'd1, 64'd1);
    out_ready = 1'b1;
    cycle();
    chk_head("bp_out2", 64'd2, 64'd2);
    cycle();
    chk_head("bp_out3", 64'd3, 64'd3);
    drive(1'b0, 32'h0, 3'b000);
    cycle();
    chk("bp_drain", 64'(out_valid32), 64'd0);

    // Flush in TWO and in ONE with a competing input.
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 3'b000);
    cycle();
    drive(1'b1, 32'h00600093, 3'b000);
    cycle();
    drive(1'b1, 32'h00700093, 3'b000);
    flush = 1'b1;
    cycle();
    chk("fl2_valid", 64'(out_valid32), 64'd0);
    chk("fl2_ready", 64'(in_ready64), 64'd1);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h00800093, 3'b000);
    cycle();
    chk_head("fl_next", 64'd8, 64'd8);
    out_ready = 1'b0;
    drive(1'b1, 32'h00900093, 3'b000);
    flush = 1'b1;
    cycle();
    chk("fl1_valid", 64'(out_valid64), 64'd0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'b000);
    cycle();
    chk("fl1_stay", 64'(out_valid32), 64'd0);

    // Asynchronous reset mid-cycle while holding one entry.
    drive(1'b1, 32'hFFF00093, 3'b000);
    cycle();
    drive(1'b0, 32'h0, 3'b000);
    @(posedge clk);
    model_step();
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_valid32", 64'(out_valid32), 64'd0);
    chk("arst_valid64", 64'(out_valid64), 64'd0);
    chk("arst_imm32", 64'(out_immext32), 64'd0);
    chk("arst_imm64", out_immext64, 64'd0);
    chk("arst_ready", 64'(in_ready32), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'b000);
    out_ready = 1'b1;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
